mips_control_fsm: RTL and testbench



---
 rtl/mips_control_fsm.sv | 233 +++++++++++++++++++++++
 tb/tb_mips_control_fsm.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mips_control_fsm.sv
// mips_control_fsm: control unit for the single-cycle 16-bit MIPS core.
// Decodes op_code/func into datapath strobes and sequences multi-cycle mult
// through the ALU ready handshake, plus halt, illegal-opcode and ALU-timeout handling.
// Optional feature macro: CTRL_PERF_CNT_EN enables the 16-bit retired-instruction counter.
//
// Ports:
//   i_clock, i_reset          : single rising-edge clock, synchronous active-high reset
//   i_op_code[5:0], i_func[5:0]: instruction fields from the datapath
//   i_ready                   : ALU result valid (only looked at in ALU_WAIT)
//   o_* strobes, o_alu_op[2:0]: datapath control
//   o_illegal                 : one-cycle pulse on an undecoded instruction
//   o_halted, o_fault         : sticky HALT / FAULT status
//   o_retired[15:0]           : retired-instruction count (0 without CTRL_PERF_CNT_EN)
module mips_control_fsm #(
  parameter int ALU_TIMEOUT = 32
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [5:0]  i_op_code,
  input  logic [5:0]  i_func,
  input  logic        i_ready,
  output logic        o_mem_to_reg,
  output logic        o_mem_write_en,
  output logic        o_reg_write_en,
  output logic        o_alu_reset,
  output logic        o_imm_sl,
  output logic        o_br_sl,
  output logic        o_reg_dest,
  output logic        o_jump_sl,
  output logic        o_breq_sl,
  output logic        o_jump_reg_sl,
  output logic        o_instr_stall_sl,
  output logic        o_hi_lo_sl,
  output logic [2:0]  o_alu_op,
  output logic        o_illegal,
  output logic        o_halted,
  output logic        o_fault,
  output logic [15:0] o_retired
);

  localparam logic [2:0] S_INIT      = 3'd0;
  localparam logic [2:0] S_EXEC      = 3'd1;
  localparam logic [2:0] S_ALU_START = 3'd2;
  localparam logic [2:0] S_ALU_WAIT  = 3'd3;
  localparam logic [2:0] S_ALU_DONE  = 3'd4;
  localparam logic [2:0] S_HALT      = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam int CNT_W = $clog2(ALU_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);

  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_MULT = 3'd6;

  logic [2:0]       r_state;
  logic [2:0]       w_state;
  logic [2:0]       w_next;
  logic [CNT_W-1:0] r_alu_cnt;

  // While reset is asserted the outputs already show INIT, even on the very
  // first cycle before the state register has been cleared.
  assign w_state = i_reset ? S_INIT : r_state;

  always_comb begin
    o_mem_to_reg     = 1'b0;
    o_mem_write_en   = 1'b0;
    o_reg_write_en   = 1'b0;
    o_alu_reset      = 1'b0;
    o_imm_sl         = 1'b0;
    o_br_sl          = 1'b0;
    o_reg_dest       = 1'b0;
    o_jump_sl        = 1'b0;
    o_breq_sl        = 1'b0;
    o_jump_reg_sl    = 1'b0;
    o_instr_stall_sl = 1'b0;
    o_hi_lo_sl       = 1'b0;
    o_alu_op         = ALU_ADD;
    o_illegal        = 1'b0;
    o_halted         = 1'b0;
    o_fault          = 1'b0;
    w_next           = w_state;

    case (w_state)
      S_INIT: begin
        o_instr_stall_sl = 1'b1;
        o_alu_reset      = 1'b1;
        w_next           = S_EXEC;
      end

      S_EXEC: begin
        case (i_op_code)
          6'h00: begin
            case (i_func)
              6'h20: begin o_reg_write_en = 1'b1; o_alu_op = ALU_ADD; end
              6'h22: begin o_reg_write_en = 1'b1; o_alu_op = ALU_SUB; end
              6'h24: begin o_reg_write_en = 1'b1; o_alu_op = ALU_AND; end
              6'h25: begin o_reg_write_en = 1'b1; o_alu_op = ALU_OR;  end
              6'h2A: begin o_reg_write_en = 1'b1; o_alu_op = ALU_SLT; end
              6'h00: begin o_reg_write_en = 1'b1; o_alu_op = ALU_SLL; end
              6'h18: begin
                // mult: hold the PC here until hi/lo are written in ALU_DONE
                o_alu_op         = ALU_MULT;
                o_instr_stall_sl = 1'b1;
                w_next           = S_ALU_START;
              end
              6'h08: begin
                o_jump_sl     = 1'b1;
                o_jump_reg_sl = 1'b1;
              end
              default: o_illegal = 1'b1;
            endcase
          end
          6'h08: begin // addi
            o_imm_sl       = 1'b1;
            o_reg_dest     = 1'b1;
            o_reg_write_en = 1'b1;
          end
          6'h23: begin // lw
            o_imm_sl       = 1'b1;
            o_reg_dest     = 1'b1;
            o_mem_to_reg   = 1'b1;
            o_reg_write_en = 1'b1;
          end
          6'h2B: begin // sw
            o_imm_sl       = 1'b1;
            o_mem_write_en = 1'b1;
          end
          6'h04: begin // beq
            o_br_sl   = 1'b1;
            o_breq_sl = 1'b1;
            o_alu_op  = ALU_SUB;
          end
          6'h05: begin // bne
            o_br_sl  = 1'b1;
            o_alu_op = ALU_SUB;
          end
          6'h02: o_jump_sl = 1'b1; // j
          6'h03: begin // jal, links to r15
            o_jump_sl      = 1'b1;
            o_reg_write_en = 1'b1;
          end
          6'h3F: begin
            // halt stalls in its own cycle so the PC parks on the halt address
            o_instr_stall_sl = 1'b1;
            w_next           = S_HALT;
          end
          default: o_illegal = 1'b1; // NOP, PC advances
        endcase
      end

      S_ALU_START: begin
        o_alu_op         = ALU_MULT;
        o_alu_reset      = 1'b1;
        o_instr_stall_sl = 1'b1;
        w_next           = S_ALU_WAIT;
      end

      S_ALU_WAIT: begin
        o_alu_op         = ALU_MULT;
        o_instr_stall_sl = 1'b1;
        if (i_ready)
          w_next = S_ALU_DONE;
        else if (r_alu_cnt == CNT_LAST)
          w_next = S_FAULT;
      end

      S_ALU_DONE: begin
        o_alu_op   = ALU_MULT;
        o_hi_lo_sl = 1'b1;
        w_next     = S_EXEC;
      end

      S_HALT: begin
        o_instr_stall_sl = 1'b1;
        o_halted         = 1'b1;
      end

      S_FAULT: begin
        o_instr_stall_sl = 1'b1;
        o_fault          = 1'b1;
      end

      default: begin
        o_instr_stall_sl = 1'b1;
        w_next           = S_INIT;
      end
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_state <= S_INIT;
    else
      r_state <= w_next;
  end

  // Wait-cycle counter: cleared in ALU_START, counts non-ready ALU_WAIT
  // cycles and saturates rather than wrapping.
  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_alu_cnt <= '0;
    else if (r_state == S_ALU_START)
      r_alu_cnt <= '0;
    else if (r_state == S_ALU_WAIT && !i_ready && r_alu_cnt != '1)
      r_alu_cnt <= r_alu_cnt + 1'b1;
  end

`ifdef CTRL_PERF_CNT_EN
  logic [15:0] r_retired;
  logic        w_retire;

  // An instruction retires whenever the PC advances out of EXEC (illegal
  // NOPs included) or a mult completes in ALU_DONE.
  assign w_retire = (r_state == S_EXEC && !o_instr_stall_sl) || (r_state == S_ALU_DONE);

  always_ff @(posedge i_clock) begin
    if (i_reset)
      r_retired <= '0;
    else if (w_retire)
      r_retired <= r_retired + 16'd1;
  end

  assign o_retired = i_reset ? 16'd0 : r_retired;
`else
  assign o_retired = 16'd0;
`endif

endmodule

// File: tb/tb_mips_control_fsm.sv
// Bench for mips_control_fsm: decode table plus hand-written mult, timeout,
// halt and reset sequences; expected strobes go through a scoreboard queue.
module tb_mips_control_fsm;

  logic        clock;
  logic        reset;
  logic [5:0]  op_code;
  logic [5:0]  func;
  logic        ready;
  logic        mem_to_reg, mem_write_en, reg_write_en, alu_reset, imm_sl, br_sl, reg_dest;
  logic        jump_sl, breq_sl, jump_reg_sl, instr_stall_sl, hi_lo_sl;
  logic [2:0]  alu_op;
  logic        illegal, halted, fault;
  logic [15:0] retired;

  mips_control_fsm #(.ALU_TIMEOUT(32)) dut (
    .i_clock(clock), .i_reset(reset), .i_op_code(op_code), .i_func(func), .i_ready(ready),
    .o_mem_to_reg(mem_to_reg), .o_mem_write_en(mem_write_en), .o_reg_write_en(reg_write_en),
    .o_alu_reset(alu_reset), .o_imm_sl(imm_sl), .o_br_sl(br_sl), .o_reg_dest(reg_dest),
    .o_jump_sl(jump_sl), .o_breq_sl(breq_sl), .o_jump_reg_sl(jump_reg_sl),
    .o_instr_stall_sl(instr_stall_sl), .o_hi_lo_sl(hi_lo_sl), .o_alu_op(alu_op),
    .o_illegal(illegal), .o_halted(halted), .o_fault(fault), .o_retired(retired)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic m2r, mwe, rwe, arst, imm, br, rd, jmp, beq, jr, stall, hilo;
    logic [2:0] aop;
    logic ill, hlt, flt;
  } ctl_t;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    ctl_t       exp;
  } vec_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vt[16];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Strobe set for an EXEC-cycle decode; every field not named is 0.
  function automatic ctl_t mk(input logic [2:0] aop, input logic rwe, input logic imm,
                              input logic rd, input logic m2r, input logic mwe,
                              input logic br, input logic beq, input logic jmp,
                              input logic jr, input logic ill);
    ctl_t c;
    c = '0;
    c.aop = aop; c.rwe = rwe; c.imm = imm; c.rd = rd; c.m2r = m2r; c.mwe = mwe;
    c.br = br; c.beq = beq; c.jmp = jmp; c.jr = jr; c.ill = ill;
    return c;
  endfunction

  ctl_t init_o, mult_exec_o, start_o, wait_o, done_o, halt_exec_o, halt_o, fault_o, add_o;

  function automatic ctl_t actual();
    ctl_t c;
    c = '{mem_to_reg, mem_write_en, reg_write_en, alu_reset, imm_sl, br_sl, reg_dest,
          jump_sl, breq_sl, jump_reg_sl, instr_stall_sl, hi_lo_sl, alu_op,
          illegal, halted, fault};
    return c;
  endfunction

  task automatic check_out();
    sb_t  s;
    ctl_t a;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_empty: got no expected entry, required one");
      return;
    end
    s = sb_q.pop_front();
    a = actual();
    n_tests++;
    if (a !== s.exp) begin
      n_fail++;
      $display("FAIL %s: got %05h required %05h", s.name, a, s.exp);
    end
  endtask

  task automatic check_ret(input string name, input logic [15:0] e);
    n_tests++;
    if (retired !== e) begin
      n_fail++;
      $display("FAIL %s: retired got %0d required %0d", name, retired, e);
    end
  endtask

  // One clock: drive just after the rising edge, compare on the falling edge.
  task automatic step(input string name, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic rdy, input ctl_t e);
    @(posedge clock);
    #1;
    reset = rst; op_code = op; func = fn; ready = rdy;
    sb_q.push_back('{name, e});
    @(negedge clock);
    check_out();
  endtask

  task automatic do_reset();
    step("rst_a", 1'b1, 6'h00, 6'h20, 1'b0, init_o);
    step("rst_b", 1'b1, 6'h00, 6'h20, 1'b0, init_o);
    step("init",  1'b0, 6'h00, 6'h20, 1'b0, init_o);
  endtask

  initial begin
    reset = 1'b1; op_code = 6'h00; func = 6'h20; ready = 1'b0;

    init_o = '0; init_o.stall = 1'b1; init_o.arst = 1'b1;
    mult_exec_o = '0; mult_exec_o.aop = 3'd6; mult_exec_o.stall = 1'b1;
    start_o = mult_exec_o; start_o.arst = 1'b1;
    wait_o = mult_exec_o;
    done_o = '0; done_o.aop = 3'd6; done_o.hilo = 1'b1;
    halt_exec_o = '0; halt_exec_o.stall = 1'b1;
    halt_o = halt_exec_o; halt_o.hlt = 1'b1;
    fault_o = halt_exec_o; fault_o.flt = 1'b1;
    add_o = mk(3'd0, 1,0,0,0,0, 0,0,0,0, 0);

    //               name    op     fn     aop  rwe imm rd m2r mwe br beq jmp jr ill
    vt[0]  = '{"add",   6'h00, 6'h20, mk(3'd0, 1,0,0,0,0, 0,0,0,0, 0)};
    vt[1]  = '{"sub",   6'h00, 6'h22, mk(3'd1, 1,0,0,0,0, 0,0,0,0, 0)};
    vt[2]  = '{"and",   6'h00, 6'h24, mk(3'd2, 1,0,0,0,0, 0,0,0,0, 0)};
    vt[3]  = '{"or",    6'h00, 6'h25, mk(3'd3, 1,0,0,0,0, 0,0,0,0, 0)};
    vt[4]  = '{"slt",   6'h00, 6'h2A, mk(3'd4, 1,0,0,0,0, 0,0,0,0, 0)};
    vt[5]  = '{"sll",   6'h00, 6'h00, mk(3'd5, 1,0,0,0,0, 0,0,0,0, 0)};
    vt[6]  = '{"jr",    6'h00, 6'h08, mk(3'd0, 0,0,0,0,0, 0,0,1,1, 0)};
    vt[7]  = '{"addi",  6'h08, 6'h15, mk(3'd0, 1,1,1,0,0, 0,0,0,0, 0)};
    vt[8]  = '{"lw",    6'h23, 6'h00, mk(3'd0, 1,1,1,1,0, 0,0,0,0, 0)};
    vt[9]  = '{"sw",    6'h2B, 6'h18, mk(3'd0, 0,1,0,0,1, 0,0,0,0, 0)};
    vt[10] = '{"beq",   6'h04, 6'h20, mk(3'd1, 0,0,0,0,0, 1,1,0,0, 0)};
    vt[11] = '{"bne",   6'h05, 6'h20, mk(3'd1, 0,0,0,0,0, 1,0,0,0, 0)};
    vt[12] = '{"j",     6'h02, 6'h00, mk(3'd0, 0,0,0,0,0, 0,0,1,0, 0)};
    vt[13] = '{"jal",   6'h03, 6'h00, mk(3'd0, 1,0,0,0,0, 0,0,1,0, 0)};
    vt[14] = '{"ill_op",6'h11, 6'h20, mk(3'd0, 0,0,0,0,0, 0,0,0,0, 1)};
    vt[15] = '{"ill_fn",6'h00, 6'h01, mk(3'd0, 0,0,0,0,0, 0,0,0,0, 1)};

    // Reset, one INIT cycle after release, then the first add.
    do_reset();
    step("add_first", 1'b0, 6'h00, 6'h20, 1'b0, add_o);
`ifndef CTRL_PERF_CNT_EN
    check_ret("ret_tied", 16'd0);
`endif

    for (int i = 0; i < 16; i++)
      step(vt[i].name, 1'b0, vt[i].op, vt[i].fn, 1'b0, vt[i].exp);
    // illegal is a single-cycle pulse: the next instruction decodes cleanly
    step("after_ill", 1'b0, 6'h00, 6'h20, 1'b1, add_o);

    // mult with ready on the 4th wait cycle; ready during START is ignored.
    step("mult_exec",  1'b0, 6'h00, 6'h18, 1'b0, mult_exec_o);
    step("mult_start", 1'b0, 6'h00, 6'h18, 1'b1, start_o);
    step("mult_w1",    1'b0, 6'h00, 6'h18, 1'b0, wait_o);
    step("mult_w2",    1'b0, 6'h00, 6'h18, 1'b0, wait_o);
    step("mult_w3",    1'b0, 6'h00, 6'h18, 1'b0, wait_o);
    step("mult_w4",    1'b0, 6'h00, 6'h18, 1'b1, wait_o);
    step("mult_done",  1'b0, 6'h00, 6'h18, 1'b0, done_o);
    step("mult_next",  1'b0, 6'h23, 6'h00, 1'b0, vt[8].exp);

    // mult timeout: 32 wait cycles without ready, then sticky FAULT.
    step("to_exec",  1'b0, 6'h00, 6'h18, 1'b0, mult_exec_o);
    step("to_start", 1'b0, 6'h00, 6'h18, 1'b0, start_o);
    for (int i = 0; i < 32; i++)
      step($sformatf("to_w%0d", i + 1), 1'b0, 6'h00, 6'h18, 1'b0, wait_o);
    step("fault_1", 1'b0, 6'h00, 6'h20, 1'b1, fault_o);
    step("fault_2", 1'b0, 6'h3F, 6'h00, 1'b0, fault_o);
    step("fault_3", 1'b0, 6'h00, 6'h18, 1'b1, fault_o);
    do_reset();
    step("post_fault_add", 1'b0, 6'h00, 6'h20, 1'b0, add_o);

    // halt stalls in its own EXEC cycle, then HALT is sticky.
    step("halt_exec", 1'b0, 6'h3F, 6'h00, 1'b0, halt_exec_o);
    step("halt_1",    1'b0, 6'h00, 6'h20, 1'b1, halt_o);
    step("halt_2",    1'b0, 6'h11, 6'h00, 1'b0, halt_o);
    do_reset();

    // reset in the middle of a mult drops the pending hi/lo write.
    step("mr_exec",  1'b0, 6'h00, 6'h18, 1'b0, mult_exec_o);
    step("mr_start", 1'b0, 6'h00, 6'h18, 1'b0, start_o);
    step("mr_w1",    1'b0, 6'h00, 6'h18, 1'b0, wait_o);
    step("mr_rst",   1'b1, 6'h00, 6'h18, 1'b1, init_o);
    step("mr_init",  1'b0, 6'h00, 6'h20, 1'b0, init_o);
    step("mr_add",   1'b0, 6'h00, 6'h20, 1'b0, add_o);

`ifdef CTRL_PERF_CNT_EN
    // 10 adds + 1 mult retire 11; then run on to the 16-bit wrap.
    do_reset();
    check_ret("ret_reset", 16'd0);
    for (int i = 0; i < 10; i++)
      step("perf_add", 1'b0, 6'h00, 6'h20, 1'b0, add_o);
    step("perf_mexec",  1'b0, 6'h00, 6'h18, 1'b0, mult_exec_o);
    step("perf_mstart", 1'b0, 6'h00, 6'h18, 1'b0, start_o);
    step("perf_mwait",  1'b0, 6'h00, 6'h18, 1'b1, wait_o);
    step("perf_mdone",  1'b0, 6'h00, 6'h18, 1'b0, done_o);
    step("perf_add11",  1'b0, 6'h00, 6'h20, 1'b0, add_o);
    check_ret("ret_11", 16'd11);
    for (int i = 0; i < 65535 - 11; i++)
      @(posedge clock);
    @(negedge clock);
    check_ret("ret_ffff", 16'hFFFF);
    @(posedge clock);
    @(negedge clock);
    check_ret("ret_wrap", 16'd0);
`else
    check_ret("ret_tied_end", 16'd0);
`endif

    if (sb_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
